relu_maxpool: RTL and testbench

Post-convolution stage of the ECG CNN datapath, directly downstream of the MAC/ALU stage. It consumes one finished convolution result per ALU valid pulse, with the ALU pulsing valid on tap count 4. For each result it adds the channel bias, applies optional ReLU, max-pools non-overlapping windows of POOL_SIZE results, and buffers pooled values in a small FIFO with a ready/valid output to the next layer. The ALU has no backpressure, so the FIFO absorbs stalls and flags any loss.

---
 rtl/ecg_cnn_pkg.sv | 11 +
 rtl/pool_fifo.sv | 52 +++++
 rtl/relu_maxpool.sv | 110 +++++++++++
 tb/tb_relu_maxpool.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ecg_cnn_pkg.sv
// Shared constants for the ECG CNN datapath: Q10.6 sample format, saturation
// limits and default sizes for the post-convolution pooling stage.
// No ports; imported by relu_maxpool.
package ecg_cnn_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 6;
  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;
  localparam int POOL_SIZE  = 2;
  localparam int FIFO_DEPTH = 8;
endpackage

// File: rtl/pool_fifo.sv
// Generic synchronous show-ahead FIFO; data_o is the head entry (stale when empty).
// Latency: a push is visible at data_o one edge later; pop takes effect on the edge.
// Backpressure: a push while full is accepted only with a same-cycle pop, else dropped.
// Ports: push_i/data_i write side, pop_i read side (ignored when empty), full_o/empty_o status.
module pool_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  // A pop on an empty FIFO is void; a full FIFO frees a slot if it pops this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/relu_maxpool.sv
// Bias add + saturate + optional ReLU, non-overlapping max-pool, output FIFO.
// Latency: last window sample at edge E0 shows on POOL_valid_out after edge E1.
// Backpressure: none upstream; FIFO absorbs stalls, drops when full, sets sticky overflow_out.
// Ports: ALU_* / bias_in / relu_en_in / frame_start_in in; POOL_* ready/valid out; overflow_out.
module relu_maxpool #(
  parameter int DATA_WIDTH = ecg_cnn_pkg::DATA_WIDTH,
  parameter int POOL_SIZE  = ecg_cnn_pkg::POOL_SIZE,
  parameter int FIFO_DEPTH = ecg_cnn_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ALU_data_in,
  input  logic                  ALU_valid_in,
  input  logic [DATA_WIDTH-1:0] bias_in,
  input  logic                  relu_en_in,
  input  logic                  frame_start_in,
  output logic [DATA_WIDTH-1:0] POOL_data_out,
  output logic                  POOL_valid_out,
  input  logic                  POOL_ready_in,
  output logic                  overflow_out
);
  import ecg_cnn_pkg::*;

  localparam int CNT_W = (POOL_SIZE > 2) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POOL_SIZE - 1);
  // Width-generic saturation bounds (equal to SAT_MAX/SAT_MIN at 16 bits).
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // ---------------- stage 1: bias, saturate, ReLU ----------------
  logic signed [DATA_WIDTH:0]   sum_w;
  logic signed [DATA_WIDTH-1:0] s1_data_d, s1_data_q;
  logic                         s1_valid_q, s1_first_q;

  assign sum_w = {ALU_data_in[DATA_WIDTH-1], ALU_data_in} + {bias_in[DATA_WIDTH-1], bias_in};

  always_comb begin
    s1_data_d = sum_w[DATA_WIDTH-1:0];
    // Sign bits disagree only when the extra carry bit overflowed the format.
    if (sum_w[DATA_WIDTH] != sum_w[DATA_WIDTH-1])
      s1_data_d = sum_w[DATA_WIDTH] ? S_MIN : S_MAX;
    if (relu_en_in && s1_data_d[DATA_WIDTH-1])
      s1_data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
    end else begin
      s1_valid_q <= ALU_valid_in;
      s1_first_q <= ALU_valid_in && frame_start_in;
      if (ALU_valid_in) s1_data_q <= s1_data_d;
    end
  end

  // ---------------- stage 2: max-pool ----------------
  logic [CNT_W-1:0]             cnt_q;
  logic signed [DATA_WIDTH-1:0] max_q, max_w;
  logic                         start_w, push_w;

  assign max_w   = (s1_data_q > max_q) ? s1_data_q : max_q;
  // A frame start always opens a new window, discarding any partial one.
  assign start_w = s1_valid_q && ((cnt_q == '0) || s1_first_q);
  assign push_w  = s1_valid_q && !start_w && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      max_q <= '0;
    end else if (start_w) begin
      max_q <= s1_data_q;
      cnt_q <= CNT_W'(1);
    end else if (push_w) begin
      cnt_q <= '0;
    end else if (s1_valid_q) begin
      max_q <= max_w;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------- output FIFO ----------------
  logic [DATA_WIDTH-1:0] head_w;
  logic                  full_w, empty_w, drop_w;

  pool_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_w),
    .data_i  (max_w),
    .pop_i   (POOL_ready_in),
    .data_o  (head_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  assign POOL_valid_out = !empty_w;
  assign POOL_data_out  = empty_w ? '0 : head_w;
  assign drop_w         = push_w && full_w && !POOL_ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        overflow_out <= 1'b0;
    else if (drop_w)                   overflow_out <= 1'b1;
    else if (s1_valid_q && s1_first_q) overflow_out <= 1'b0;
  end
endmodule

// File: tb/tb_relu_maxpool.sv
module tb_relu_maxpool;
  logic        clk, rst_n;
  logic [15:0] alu_d, bias;
  logic        alu_v, relu_en, fs, ready;
  logic [15:0] pool_d;
  logic        pool_v, ovf;

  int errors = 0;
  int checks = 0;

  // Model state: expected FIFO contents, current pooling window, overflow flag.
  logic [15:0] exp_q[$];
  int          win[$];
  bit          exp_ovf;
  int          push_cnt;
  logic [15:0] last_pushed;

  relu_maxpool dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ALU_data_in    (alu_d),
    .ALU_valid_in   (alu_v),
    .bias_in        (bias),
    .relu_en_in     (relu_en),
    .frame_start_in (fs),
    .POOL_data_out  (pool_d),
    .POOL_valid_out (pool_v),
    .POOL_ready_in  (ready),
    .overflow_out   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] stage_val(input logic [15:0] a, input logic [15:0] b, input bit r);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (r && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic model_sample(input logic [15:0] v, input bit first);
    int m;
    if (first) begin
      win.delete();
      exp_ovf = 1'b0;
    end
    win.push_back(int'($signed(v)));
    if (win.size() == 2) begin
      m = win[0];
      foreach (win[i]) if (win[i] > m) m = win[i];
      last_pushed = 16'(m);
      push_cnt++;
      if (exp_q.size() >= 8) exp_ovf = 1'b1;
      else exp_q.push_back(16'(m));
      win.delete();
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit r, input bit f);
    @(negedge clk);
    alu_d = a; bias = b; relu_en = r; fs = f; alu_v = 1'b1;
    model_sample(stage_val(a, b, r), f);
    @(posedge clk); #1;
    alu_v = 1'b0; fs = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Compare process: just before every rising edge, check the head against the model.
  initial begin
    forever begin
      @(negedge clk); #4;
      if (!pool_v) begin
        chk("idle_data_zero", pool_d, 0);
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got data %0h expected no entry", pool_d);
      end else begin
        chk("fifo_head", pool_d, exp_q[0]);
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  logic [15:0] t_alu  [5] = '{16'h0100, 16'hFF00, 16'hFF00, 16'h7F00, 16'h8100};
  logic [15:0] t_bias [5] = '{16'hFFC0, 16'h0000, 16'h0000, 16'h0200, 16'hFE00};
  bit          t_relu [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] t_exp  [5] = '{16'h00C0, 16'h0000, 16'hFF00, 16'h7FFF, 16'h8000};

  initial begin
    int pc0;
    rst_n = 1'b0; alu_d = '0; bias = '0; alu_v = 1'b0; relu_en = 1'b0; fs = 1'b0; ready = 1'b0;
    exp_ovf = 1'b0; push_cnt = 0; last_pushed = '0;
    #12;
    chk("reset_valid", pool_v, 0);
    chk("reset_data", pool_d, 0);
    chk("reset_ovf", ovf, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Bias / ReLU / saturation: each value paired with the most negative sample,
    // so the pooled output is the stage value itself.
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(t_alu[i], t_bias[i], t_relu[i], 1'b0);
      send(16'h8000, 16'h0000, 1'b0, 1'b0);
      chk($sformatf("stage_model_%0d", i), last_pushed, t_exp[i]);
    end
    repeat (4) step();

    // Pooling 5,9,3,2 -> 9,3 with 2-cycle latency.
    ready = 1'b0;
    send(16'd5, 16'd0, 1'b0, 1'b0);
    send(16'd9, 16'd0, 1'b0, 1'b0);
    chk("lat_not_yet_valid", pool_v, 0);
    step();
    chk("lat_valid", pool_v, 1);
    chk("pool_first", pool_d, 16'd9);
    send(16'd3, 16'd0, 1'b0, 1'b0);
    send(16'd2, 16'd0, 1'b0, 1'b0);
    step();
    ready = 1'b1;
    step();
    chk("pool_second", pool_d, 16'd3);
    step();
    chk("pool_drained", pool_v, 0);

    // frame_start mid-window: 7 | 4(fs) 6 -> single output 6.
    ready = 1'b0;
    pc0 = push_cnt;
    send(16'd7, 16'd0, 1'b0, 1'b0);
    send(16'd4, 16'd0, 1'b0, 1'b1);
    send(16'd6, 16'd0, 1'b0, 1'b0);
    chk("fs_model_count", push_cnt - pc0, 1);
    chk("fs_model_value", last_pushed, 16'd6);
    step();
    chk("fs_valid", pool_v, 1);
    chk("fs_data", pool_d, 16'd6);
    ready = 1'b1;
    step();
    chk("fs_single", pool_v, 0);

    // Backpressure: 9 pooled values (10,20,..,90) into a stalled FIFO.
    ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      send(16'(10 * k), 16'd0, 1'b0, 1'b0);
      send(16'(10 * k - 1), 16'd0, 1'b0, 1'b0);
    end
    step();
    chk("ovf_model_depth", exp_q.size(), 8);
    chk("ovf_model_flag", exp_ovf, 1);
    chk("ovf_set", ovf, 1);
    chk("ovf_head", pool_d, 16'd10);
    repeat (3) step();
    chk("ovf_head_stable", pool_d, 16'd10);
    ready = 1'b1;
    repeat (7) step();
    chk("drain_last_valid", pool_v, 1);
    chk("drain_last_data", pool_d, 16'd80);
    step();
    chk("drain_empty", pool_v, 0);
    chk("ovf_sticky", ovf, 1);
    send(16'd5, 16'd0, 1'b0, 1'b1);
    step();
    chk("ovf_cleared", ovf, 0);
    send(16'd1, 16'd0, 1'b0, 1'b0);
    repeat (4) step();

    // Reset with 3 entries buffered and a half-filled window.
    ready = 1'b0;
    send(16'd1, 16'd0, 1'b0, 1'b0); send(16'd2, 16'd0, 1'b0, 1'b0);
    send(16'd3, 16'd0, 1'b0, 1'b0); send(16'd4, 16'd0, 1'b0, 1'b0);
    send(16'd5, 16'd0, 1'b0, 1'b0); send(16'd6, 16'd0, 1'b0, 1'b0);
    send(16'd7, 16'd0, 1'b0, 1'b0);
    step();
    chk("prerst_head", pool_d, 16'd2);
    @(negedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete(); win.delete(); exp_ovf = 1'b0;
    #1;
    chk("rst_async_valid", pool_v, 0);
    chk("rst_async_data", pool_d, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    send(16'd3, 16'd0, 1'b0, 1'b0);
    send(16'd8, 16'd0, 1'b0, 1'b0);
    step();
    chk("post_rst_valid", pool_v, 1);
    chk("post_rst_window", pool_d, 16'd8);
    ready = 1'b1;
    step();
    chk("post_rst_single", pool_v, 0);
    repeat (3) step();
    chk("model_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
